// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style sequencer driving the 8-bit MIPS multi-cycle datapath.
// Build with PERF_COUNT_EN defined to add the retired_count / cycle_count outputs.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    input  logic       mem_ack,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       regDst,
    output logic       alusrc,
    output logic       memToReg,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] alu_op,
    output logic [2:0] state_out,
    output logic       halted,
    output logic       error
`ifdef PERF_COUNT_EN
    ,
    output logic [15:0] retired_count,
    output logic [15:0] cycle_count
`endif
);

    // state  | meaning
    // FETCH  | latch instruction register, capture opcode/funct
    // DECODE | dispatch on opcode; j completes here
    // EXEC   | alu operation; beq completes here
    // MEM    | hold mem_read/mem_write until mem_ack or timeout
    // WB     | register file write-back, pc advance
    // HALT   | idle until reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          r_state;
    logic [5:0]      r_opcode;
    logic [5:0]      r_funct;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_error;

    state_t          w_state_next;
    logic [TO_W-1:0] w_to_cnt_next;
    logic [TO_W-1:0] w_to_inc;
    logic            w_err_set;

    logic            w_is_r;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_is_beq;
    logic            w_is_addi;
    logic            w_funct_ok;
    logic [3:0]      w_funct_alu;

    logic            w_ir_write;
    logic            w_pc_write;
    logic [1:0]      w_pc_src;
    logic            w_reg_write;
    logic            w_reg_dst;
    logic            w_alusrc;
    logic            w_mem_to_reg;
    logic            w_mem_read;
    logic            w_mem_write;
    logic [3:0]      w_alu_op;

    assign w_is_r    = (r_opcode == OP_RTYPE);
    assign w_is_lw   = (r_opcode == OP_LW);
    assign w_is_sw   = (r_opcode == OP_SW);
    assign w_is_beq  = (r_opcode == OP_BEQ);
    assign w_is_addi = (r_opcode == OP_ADDI);
    assign w_to_inc  = r_to_cnt + 1'b1;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (r_funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_opcode <= 6'd0;
            r_funct  <= 6'd0;
            r_to_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_to_cnt <= w_to_cnt_next;
            r_error  <= r_error | w_err_set;
            if (r_state == S_FETCH) begin
                r_opcode <= opcode;
                r_funct  <= funct;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_to_cnt_next = r_to_cnt;
        w_err_set     = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = 2'b00;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_alusrc      = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_alu_op      = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write    = 1'b1;
                w_to_cnt_next = '0;
                w_state_next  = S_DECODE;
            end
            S_DECODE: begin
                if (r_opcode == OP_J) begin
                    w_pc_write   = 1'b1;
                    w_pc_src     = 2'b10;
                    w_state_next = S_FETCH;
                end else if (r_opcode == OP_HALT) begin
                    w_state_next = S_HALT;
                end else if ((w_is_r && w_funct_ok) || w_is_lw || w_is_sw || w_is_beq || w_is_addi) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_err_set    = 1'b1;
                    w_state_next = S_HALT;
                end
            end
            S_EXEC: begin
                if (w_is_r) begin
                    w_alu_op     = w_funct_alu;
                    w_state_next = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_alusrc     = 1'b1;
                    w_state_next = S_MEM;
                end else if (w_is_addi) begin
                    w_alusrc     = 1'b1;
                    w_state_next = S_WB;
                end else if (w_is_beq) begin
                    w_alu_op     = ALU_SUB;
                    w_pc_write   = 1'b1;
                    w_pc_src     = {1'b0, zero_flag};
                    w_state_next = S_FETCH;
                end else begin
                    w_err_set    = 1'b1;
                    w_state_next = S_HALT;
                end
            end
            S_MEM: begin
                w_alusrc    = 1'b1;
                w_mem_read  = w_is_lw;
                w_mem_write = w_is_sw;
                if (mem_ack) begin
                    w_to_cnt_next = '0;
                    if (w_is_lw) begin
                        w_state_next = S_WB;
                    end else begin
                        w_pc_write   = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end else begin
                    // the cycle that would reach the limit is the last one spent waiting
                    w_to_cnt_next = w_to_inc;
                    if (w_to_inc == TO_LIMIT) begin
                        w_err_set    = 1'b1;
                        w_state_next = S_HALT;
                    end
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_pc_write   = 1'b1;
                w_reg_dst    = w_is_r;
                w_mem_to_reg = w_is_lw;
                w_alusrc     = w_is_addi;
                w_alu_op     = w_is_r ? w_funct_alu : ALU_ADD;
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_err_set    = 1'b1;
                w_state_next = S_HALT;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held so an aborted instruction cannot strobe.
    assign ir_write  = reset & w_ir_write;
    assign pc_write  = reset & w_pc_write;
    assign pc_src    = reset ? w_pc_src : 2'b00;
    assign reg_write = reset & w_reg_write;
    assign regDst    = reset & w_reg_dst;
    assign alusrc    = reset & w_alusrc;
    assign memToReg  = reset & w_mem_to_reg;
    assign mem_read  = reset & w_mem_read;
    assign mem_write = reset & w_mem_write;
    assign alu_op    = reset ? w_alu_op : ALU_ADD;
    assign state_out = r_state;
    assign halted    = (r_state == S_HALT);
    assign error     = r_error;

`ifdef PERF_COUNT_EN
    logic [15:0] r_retired_count;
    logic [15:0] r_cycle_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired_count <= 16'd0;
            r_cycle_count   <= 16'd0;
        end else begin
            if (w_pc_write) begin
                r_retired_count <= r_retired_count + 16'd1;
            end
            if (r_state != S_HALT) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
        end
    end

    assign retired_count = r_retired_count;
    assign cycle_count   = r_cycle_count;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions checked against a latency/effect table.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam int         MEM_TO  = 15;
    localparam int         NEVER   = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero_flag;
    logic        mem_ack;
    logic        ir_write, pc_write, reg_write, regDst, alusrc, memToReg;
    logic        mem_read, mem_write, halted, error;
    logic [1:0]  pc_src;
    logic [3:0]  alu_op;
    logic [2:0]  state_out;
`ifdef PERF_COUNT_EN
    logic [15:0] retired_count;
    logic [15:0] cycle_count;
`endif

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero_flag (zero_flag),
        .mem_ack   (mem_ack),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .regDst    (regDst),
        .alusrc    (alusrc),
        .memToReg  (memToReg),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_op    (alu_op),
        .state_out (state_out),
        .halted    (halted),
        .error     (error)
`ifdef PERF_COUNT_EN
        ,
        .retired_count (retired_count),
        .cycle_count   (cycle_count)
`endif
    );

    logic [11:0] strobes;
    assign strobes = {ir_write, pc_write, pc_src, reg_write, regDst, alusrc,
                      memToReg, mem_read, mem_write, halted, error};

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] pcw;
        logic [31:0] pcsrc;
        logic [31:0] rw;
        logic [31:0] regdst;
        logic [31:0] m2r;
        logic [31:0] wb_alusrc;
        logic [31:0] mr;
        logic [31:0] mw;
        logic [31:0] has_exec;
        logic [31:0] exec_alu;
        logic [31:0] exec_alusrc;
        logic [31:0] halt;
        logic [31:0] err;
    } exp_t;

    logic [31:0] ob_cyc, ob_pcw, ob_pcsrc, ob_rw, ob_regdst, ob_m2r, ob_wb_alusrc;
    logic [31:0] ob_mr, ob_mw, ob_irw, ob_bad, ob_exec_alu, ob_exec_alusrc, ob_halt, ob_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    function automatic logic [31:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 32'd2;
            6'b100010: return 32'd6;
            6'b100100: return 32'd0;
            6'b100101: return 32'd1;
            6'b101010: return 32'd7;
            default:   return 32'hFF;
        endcase
    endfunction

    // Whole-instruction effects: latency, strobe counts and the select values seen on them.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic zf, input int wt);
        exp_t e;
        e = '{default: 32'd0};
        case (op)
            OP_J: begin
                e.cyc = 2; e.pcw = 1; e.pcsrc = 2;
            end
            OP_HALT: begin
                e.cyc = 3; e.halt = 1;
            end
            OP_R: begin
                if (alu_of(fn) == 32'hFF) begin
                    e.cyc = 3; e.halt = 1; e.err = 1;
                end else begin
                    e.cyc = 4; e.pcw = 1; e.rw = 1; e.regdst = 1;
                    e.has_exec = 1; e.exec_alu = alu_of(fn);
                end
            end
            OP_ADDI: begin
                e.cyc = 4; e.pcw = 1; e.rw = 1; e.wb_alusrc = 1;
                e.has_exec = 1; e.exec_alu = 2; e.exec_alusrc = 1;
            end
            OP_BEQ: begin
                e.cyc = 3; e.pcw = 1; e.pcsrc = zf ? 32'd1 : 32'd0;
                e.has_exec = 1; e.exec_alu = 6;
            end
            OP_LW: begin
                e.has_exec = 1; e.exec_alu = 2; e.exec_alusrc = 1;
                if (wt < MEM_TO) begin
                    e.cyc = 5 + wt; e.pcw = 1; e.rw = 1; e.m2r = 1; e.mr = wt + 1;
                end else begin
                    e.cyc = MEM_TO + 4; e.mr = MEM_TO; e.halt = 1; e.err = 1;
                end
            end
            OP_SW: begin
                e.has_exec = 1; e.exec_alu = 2; e.exec_alusrc = 1;
                if (wt < MEM_TO) begin
                    e.cyc = 4 + wt; e.pcw = 1; e.mw = wt + 1;
                end else begin
                    e.cyc = MEM_TO + 4; e.mw = MEM_TO; e.halt = 1; e.err = 1;
                end
            end
            default: begin
                e.cyc = 3; e.halt = 1; e.err = 1;
            end
        endcase
        return e;
    endfunction

    // Starts at a falling edge with the controller in FETCH; acks after wt extra memory cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zf, input int wt);
        int  memcnt;
        bit  done;
        memcnt = 0;
        done   = 1'b0;
        opcode = op; funct = fn; zero_flag = zf;
        ob_cyc = 0; ob_pcw = 0; ob_pcsrc = 32'hFF; ob_rw = 0; ob_regdst = 32'hFF; ob_m2r = 32'hFF;
        ob_wb_alusrc = 32'hFF; ob_mr = 0; ob_mw = 0; ob_irw = 0; ob_bad = 0;
        ob_exec_alu = 32'hFF; ob_exec_alusrc = 32'hFF; ob_halt = 0; ob_err = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_read || mem_write) begin
                mem_ack = (memcnt == wt);
                memcnt++;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            ob_cyc = 32'(c + 1);
            if (ir_write) ob_irw++;
            if (mem_read) ob_mr++;
            if (mem_write) ob_mw++;
            if ((mem_read && mem_write) || (reg_write && mem_write)) ob_bad++;
            if (state_out == 3'd2) begin
                ob_exec_alu    = 32'(alu_op);
                ob_exec_alusrc = 32'(alusrc);
            end
            if (reg_write) begin
                ob_rw++;
                ob_regdst    = 32'(regDst);
                ob_m2r       = 32'(memToReg);
                ob_wb_alusrc = 32'(alusrc);
            end
            if (pc_write) begin
                ob_pcw++;
                ob_pcsrc = 32'(pc_src);
            end
            if (pc_write || halted) begin
                ob_halt = 32'(halted);
                ob_err  = 32'(error);
                done    = 1'b1;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic check_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                               input logic zf, input int wt);
        exp_t e;
        e = model(op, fn, zf, wt);
        run_instr(op, fn, zf, wt);
        chk({tag, ".cycles"}, ob_cyc, e.cyc);
        chk({tag, ".pc_writes"}, ob_pcw, e.pcw);
        chk({tag, ".ir_writes"}, ob_irw, 32'd1);
        chk({tag, ".reg_writes"}, ob_rw, e.rw);
        chk({tag, ".mem_read_cycles"}, ob_mr, e.mr);
        chk({tag, ".mem_write_cycles"}, ob_mw, e.mw);
        chk({tag, ".halted"}, ob_halt, e.halt);
        chk({tag, ".error"}, ob_err, e.err);
        chk({tag, ".exclusive"}, ob_bad, 32'd0);
        if (e.pcw != 0) chk({tag, ".pc_src"}, ob_pcsrc, e.pcsrc);
        if (e.rw != 0) begin
            chk({tag, ".regDst"}, ob_regdst, e.regdst);
            chk({tag, ".memToReg"}, ob_m2r, e.m2r);
            chk({tag, ".wb_alusrc"}, ob_wb_alusrc, e.wb_alusrc);
        end
        if (e.has_exec != 0) begin
            chk({tag, ".exec_alu_op"}, ob_exec_alu, e.exec_alu);
            chk({tag, ".exec_alusrc"}, ob_exec_alusrc, e.exec_alusrc);
        end
    endtask

    // Leaves reset released on a falling edge with the controller in FETCH.
    task automatic do_reset(input string tag);
        reset   = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk({tag, ".state"}, 32'(state_out), 32'd0);
        chk({tag, ".strobes"}, 32'(strobes), 32'd0);
        chk({tag, ".alu_op"}, 32'(alu_op), 32'd2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [5:0] r_op, r_fn;
        logic       r_zf;
        int         r_wt, k;

        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero_flag = 1'b0; mem_ack = 1'b0;
        #2;
        do_reset("reset0");

        check_instr("add", OP_R, 6'b100000, 1'b0, 0);
        check_instr("sub", OP_R, 6'b100010, 1'b1, 0);
        check_instr("slt", OP_R, 6'b101010, 1'b0, 0);
        check_instr("lw_ack3", OP_LW, 6'd0, 1'b0, 2);
        check_instr("lw_ack1", OP_LW, 6'd7, 1'b0, 0);
        check_instr("lw_ack15", OP_LW, 6'd0, 1'b0, MEM_TO - 1);
        check_instr("sw_ack1", OP_SW, 6'd0, 1'b0, 0);
        check_instr("sw_ack15", OP_SW, 6'd0, 1'b1, MEM_TO - 1);
        check_instr("beq_taken", OP_BEQ, 6'd0, 1'b1, 0);
        check_instr("beq_not", OP_BEQ, 6'd0, 1'b0, 0);
        check_instr("addi", OP_ADDI, 6'd0, 1'b0, 0);
        check_instr("j", OP_J, 6'd0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            k    = int'($urandom_range(0, 9));
            r_fn = 6'($urandom);
            r_zf = 1'($urandom_range(0, 1));
            r_wt = int'($urandom_range(0, 6));
            case (k)
                0: begin r_op = OP_R; r_fn = 6'b100000; end
                1: begin r_op = OP_R; r_fn = 6'b100010; end
                2: begin r_op = OP_R; r_fn = 6'b100100; end
                3: begin r_op = OP_R; r_fn = 6'b100101; end
                4: begin r_op = OP_R; r_fn = 6'b101010; end
                5: r_op = OP_LW;
                6: r_op = OP_SW;
                7: r_op = OP_BEQ;
                8: r_op = OP_ADDI;
                default: r_op = OP_J;
            endcase
            check_instr($sformatf("rnd%0d", i), r_op, r_fn, r_zf, r_wt);
        end

        check_instr("sw_timeout", OP_SW, 6'd0, 1'b0, NEVER);
        repeat (5) @(negedge clk);
        #1;
        chk("sw_timeout.hold_halted", 32'(halted), 32'd1);
        chk("sw_timeout.hold_mem_write", 32'(mem_write), 32'd0);
        chk("sw_timeout.hold_error", 32'(error), 32'd1);
        chk("sw_timeout.hold_state", 32'(state_out), 32'd7);
        do_reset("reset_after_timeout");

        check_instr("lw_timeout", OP_LW, 6'd0, 1'b0, NEVER);
        do_reset("reset_after_lw_timeout");

        check_instr("bad_opcode", 6'b010101, 6'd0, 1'b0, 0);
        do_reset("reset_after_bad_op");
        check_instr("bad_funct", OP_R, 6'b100001, 1'b0, 0);
        do_reset("reset_after_bad_funct");

        check_instr("halt", OP_HALT, 6'd0, 1'b0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("halt.hold_state", 32'(state_out), 32'd7);
        chk("halt.hold_pc_write", 32'(pc_write), 32'd0);
        do_reset("reset_after_halt");

        opcode = OP_LW; funct = 6'd0; mem_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("midlw.mem_read", 32'(mem_read), 32'd1);
        reset = 1'b0;
        #1;
        chk("midlw.reset_strobes", 32'(strobes), 32'd0);
        chk("midlw.reset_state", 32'(state_out), 32'd0);
        @(negedge clk);
        #1;
        chk("midlw.reset_hold_strobes", 32'(strobes), 32'd0);
        reset = 1'b1;
        #1;
        chk("midlw.release_state", 32'(state_out), 32'd0);
        chk("midlw.release_ir_write", 32'(ir_write), 32'd1);
        @(negedge clk);
        do_reset("reset_before_add");
        check_instr("add_after_abort", OP_R, 6'b100000, 1'b0, 0);

`ifdef PERF_COUNT_EN
        do_reset("reset_perf");
        check_instr("perf_j", OP_J, 6'd0, 1'b0, 0);
        check_instr("perf_add", OP_R, 6'b100000, 1'b0, 0);
        check_instr("perf_halt", OP_HALT, 6'd0, 1'b0, 0);
        #1;
        chk("perf.retired", 32'(retired_count), 32'd2);
        chk("perf.cycles", 32'(cycle_count), 32'd8);
        repeat (4) @(negedge clk);
        #1;
        chk("perf.retired_frozen", 32'(retired_count), 32'd2);
        chk("perf.cycles_frozen", 32'(cycle_count), 32'd8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
